// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface instruction_fetch_unit_if;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Rdata;

  modport master (
    output Imem_Req,
    output Imem_Addr,
    input  Imem_Ack,
    input  Imem_Rdata
  );

  modport slave (
    input  Imem_Req,
    input  Imem_Addr,
    output Imem_Ack,
    output Imem_Rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, selects next PC (sequential / branch / jump), and
// handshakes with a variable-latency instruction memory. Presents one
// instruction plus its PC+4 to IF/ID with a valid qualifier; bubbles are NOPs.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PC_Enable,
  input  logic                     Branch_Taken,
  input  logic [31:0]              Branch_Target,
  input  logic                     Jump_Taken,
  input  logic [25:0]              Jump_Offset,
  input  logic [31:0]              Jump_PC_Plus_4,
  instruction_fetch_unit_if.master imem,
  output logic [31:0]              Instruction,
  output logic [31:0]              PC_Counter_Input,
  output logic                     Fetch_Valid,
  output logic                     Fetch_Busy
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_buf, instr_buf_next;
  logic [31:0] drop_addr, drop_addr_next;
  logic        req;
  logic [31:0] addr;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Branch is the older instruction, so it wins over a jump in the same cycle.
  function automatic logic [31:0] redirect_target(
    input logic        br,
    input logic [31:0] br_tgt,
    input logic [25:0] j_off,
    input logic [31:0] j_pc4
  );
    if (br) return {br_tgt[31:2], 2'b00};
    return {j_pc4[31:28], j_off, 2'b00};
  endfunction

  assign redirect = Branch_Taken | Jump_Taken;
  assign target   = redirect_target(Branch_Taken, Branch_Target, Jump_Offset, Jump_PC_Plus_4);
  assign pc_plus4 = pc + 32'd4;

  assign imem.Imem_Req  = req;
  assign imem.Imem_Addr = addr;

  // Low target bits are forced to zero and never observed.
  logic unused_bits;
  assign unused_bits = ^{Branch_Target[1:0], Jump_PC_Plus_4[27:0]};

  // State, PC and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr_buf <= 32'h0;
      drop_addr <= 32'h0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      instr_buf <= instr_buf_next;
      drop_addr <= drop_addr_next;
    end
  end

  // Next-state, next-PC and all IF/ID and memory-side outputs.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_buf_next   = instr_buf;
    drop_addr_next   = drop_addr;
    req              = 1'b0;
    addr             = pc;
    Instruction      = NOP_INSTR;
    PC_Counter_Input = 32'h0;
    Fetch_Valid      = 1'b0;
    Fetch_Busy       = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        req        = 1'b1;
        Fetch_Busy = ~imem.Imem_Ack;
        if (redirect) begin
          // Flush beats stall; a pending request must still complete, so it
          // is tracked at its original address in DROP.
          pc_next = target;
          if (!imem.Imem_Ack) begin
            drop_addr_next = pc;
            state_next     = DROP;
          end
        end else if (imem.Imem_Ack) begin
          Instruction      = imem.Imem_Rdata;
          PC_Counter_Input = pc_plus4;
          Fetch_Valid      = 1'b1;
          if (PC_Enable) begin
            pc_next = pc_plus4;
          end else begin
            instr_buf_next = imem.Imem_Rdata;
            state_next     = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = FETCH;
        end else begin
          Instruction      = instr_buf;
          PC_Counter_Input = pc_plus4;
          Fetch_Valid      = 1'b1;
          if (PC_Enable) begin
            pc_next    = pc_plus4;
            state_next = FETCH;
          end
        end
      end
      DROP: begin
        req        = 1'b1;
        addr       = drop_addr;
        Fetch_Busy = ~imem.Imem_Ack;
        // A redirect here only moves the PC; the stale request still drains.
        if (redirect) pc_next = target;
        if (imem.Imem_Ack) state_next = FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with hand-computed expectations.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_Enable;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump_Taken;
  logic [25:0] Jump_Offset;
  logic [31:0] Jump_PC_Plus_4;
  logic [31:0] Instruction;
  logic [31:0] PC_Counter_Input;
  logic        Fetch_Valid;
  logic        Fetch_Busy;

  int tests = 0;
  int fails = 0;

  instruction_fetch_unit_if mem ();

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PC_Enable       (PC_Enable),
    .Branch_Taken    (Branch_Taken),
    .Branch_Target   (Branch_Target),
    .Jump_Taken      (Jump_Taken),
    .Jump_Offset     (Jump_Offset),
    .Jump_PC_Plus_4  (Jump_PC_Plus_4),
    .imem            (mem),
    .Instruction     (Instruction),
    .PC_Counter_Input(PC_Counter_Input),
    .Fetch_Valid     (Fetch_Valid),
    .Fetch_Busy      (Fetch_Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    PC_Enable         = 1'b1;
    Branch_Taken      = 1'b0;
    Branch_Target     = 32'h0;
    Jump_Taken        = 1'b0;
    Jump_Offset       = 26'h0;
    Jump_PC_Plus_4    = 32'h0;
    mem.Imem_Ack      = 1'b1;
    mem.Imem_Rdata    = 32'hFFFF_FFFF;
    #2;
    chk("rst_req",   32'(mem.Imem_Req), 32'd0);
    chk("rst_addr",  mem.Imem_Addr,     32'h0);
    chk("rst_instr", Instruction,       32'h0);
    chk("rst_pc4",   PC_Counter_Input,  32'h0);
    chk("rst_valid", 32'(Fetch_Valid),  32'd0);
    chk("rst_busy",  32'(Fetch_Busy),   32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_req",   32'(mem.Imem_Req), 32'd0);
    chk("idle_valid", 32'(Fetch_Valid),  32'd0);

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      tick();
      mem.Imem_Rdata = 32'hA000_0000 + i;
      #1;
      chk("seq_addr",  mem.Imem_Addr,     32'(4 * i));
      chk("seq_req",   32'(mem.Imem_Req), 32'd1);
      chk("seq_valid", 32'(Fetch_Valid),  32'd1);
      chk("seq_instr", Instruction,       32'hA000_0000 + i);
      chk("seq_pc4",   PC_Counter_Input,  32'(4 * (i + 1)));
    end
    for (int i = 4; i < 8; i++) begin
      tick();
      mem.Imem_Rdata = 32'hA000_0000 + i;
      #1;
      chk("fill_addr", mem.Imem_Addr, 32'(4 * i));
    end

    // three wait cycles at 0x20
    for (int k = 0; k < 3; k++) begin
      tick();
      mem.Imem_Ack = 1'b0;
      #1;
      chk("wait_addr",  mem.Imem_Addr,    32'h20);
      chk("wait_busy",  32'(Fetch_Busy),  32'd1);
      chk("wait_instr", Instruction,      32'h0);
      chk("wait_valid", 32'(Fetch_Valid), 32'd0);
    end
    tick();
    mem.Imem_Ack   = 1'b1;
    mem.Imem_Rdata = 32'hDEAD_0020;
    #1;
    chk("ack_instr", Instruction,      32'hDEAD_0020);
    chk("ack_pc4",   PC_Counter_Input, 32'h24);
    chk("ack_valid", 32'(Fetch_Valid), 32'd1);
    chk("ack_busy",  32'(Fetch_Busy),  32'd0);
    for (int i = 9; i < 16; i++) begin
      tick();
      #1;
      chk("fill2_addr", mem.Imem_Addr, 32'(4 * i));
    end

    // stall with data at 0x40
    tick();
    PC_Enable      = 1'b0;
    mem.Imem_Rdata = 32'hBEEF_0040;
    #1;
    chk("stall_addr",  mem.Imem_Addr,    32'h40);
    chk("stall_valid", 32'(Fetch_Valid), 32'd1);
    chk("stall_instr", Instruction,      32'hBEEF_0040);
    tick();
    mem.Imem_Ack   = 1'b0;
    mem.Imem_Rdata = 32'h1234_5678;
    #1;
    chk("hold_instr", Instruction,       32'hBEEF_0040);
    chk("hold_req",   32'(mem.Imem_Req), 32'd0);
    chk("hold_valid", 32'(Fetch_Valid),  32'd1);
    chk("hold_pc4",   PC_Counter_Input,  32'h44);
    tick();
    PC_Enable = 1'b1;
    #1;
    chk("hold2_instr", Instruction,       32'hBEEF_0040);
    chk("hold2_req",   32'(mem.Imem_Req), 32'd0);
    tick();
    mem.Imem_Ack = 1'b1;
    #1;
    chk("resume_addr", mem.Imem_Addr,     32'h44);
    chk("resume_req",  32'(mem.Imem_Req), 32'd1);
    tick(); #1;
    chk("a48_addr", mem.Imem_Addr, 32'h48);
    tick(); #1;
    chk("a4c_addr", mem.Imem_Addr, 32'h4C);

    // branch while request at 0x50 is waiting
    tick();
    mem.Imem_Ack  = 1'b0;
    Branch_Taken  = 1'b1;
    Branch_Target = 32'h103;
    #1;
    chk("br_addr",  mem.Imem_Addr,    32'h50);
    chk("br_valid", 32'(Fetch_Valid), 32'd0);
    chk("br_busy",  32'(Fetch_Busy),  32'd1);
    tick();
    Branch_Taken = 1'b0;
    #1;
    chk("drop_addr", mem.Imem_Addr,     32'h50);
    chk("drop_req",  32'(mem.Imem_Req), 32'd1);
    chk("drop_busy", 32'(Fetch_Busy),   32'd1);
    tick();
    mem.Imem_Ack   = 1'b1;
    mem.Imem_Rdata = 32'h5555_5555;
    #1;
    chk("dack_addr",  mem.Imem_Addr,    32'h50);
    chk("dack_valid", 32'(Fetch_Valid), 32'd0);
    chk("dack_instr", Instruction,      32'h0);
    chk("dack_busy",  32'(Fetch_Busy),  32'd0);
    tick();
    mem.Imem_Ack = 1'b0;
    #1;
    chk("tgt_addr", mem.Imem_Addr,     32'h100);
    chk("tgt_req",  32'(mem.Imem_Req), 32'd1);

    // branch and jump together, with ack in the same cycle
    tick();
    mem.Imem_Ack   = 1'b1;
    Branch_Taken   = 1'b1;
    Branch_Target  = 32'h200;
    Jump_Taken     = 1'b1;
    Jump_PC_Plus_4 = 32'h9000_0010;
    Jump_Offset    = 26'h10;
    #1;
    chk("bj_valid", 32'(Fetch_Valid), 32'd0);
    chk("bj_instr", Instruction,      32'h0);
    tick();
    Branch_Taken = 1'b0;
    Jump_Taken   = 1'b0;
    mem.Imem_Ack = 1'b0;
    #1;
    chk("bj_addr", mem.Imem_Addr, 32'h200);

    // jump alone
    tick();
    mem.Imem_Ack = 1'b1;
    Jump_Taken   = 1'b1;
    #1;
    chk("j_valid", 32'(Fetch_Valid), 32'd0);
    tick();
    Jump_Taken    = 1'b0;
    Branch_Taken  = 1'b1;
    Branch_Target = 32'hFFFF_FFFF;
    #1;
    chk("j_addr",    mem.Imem_Addr,    32'h9000_0040);
    chk("br2_valid", 32'(Fetch_Valid), 32'd0);

    // wrap at top of address space
    tick();
    Branch_Taken   = 1'b0;
    mem.Imem_Rdata = 32'h7777_7777;
    #1;
    chk("wrap_addr",  mem.Imem_Addr,    32'hFFFF_FFFC);
    chk("wrap_valid", 32'(Fetch_Valid), 32'd1);
    chk("wrap_pc4",   PC_Counter_Input, 32'h0);
    chk("wrap_instr", Instruction,      32'h7777_7777);
    tick(); #1;
    chk("zero_addr", mem.Imem_Addr,    32'h0);
    chk("zero_pc4",  PC_Counter_Input, 32'h4);

    // reset in the middle of a wait
    tick();
    mem.Imem_Ack = 1'b0;
    #1;
    chk("mid_addr", mem.Imem_Addr,   32'h4);
    chk("mid_busy", 32'(Fetch_Busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req",   32'(mem.Imem_Req), 32'd0);
    chk("mrst_addr",  mem.Imem_Addr,     32'h0);
    chk("mrst_busy",  32'(Fetch_Busy),   32'd0);
    chk("mrst_valid", 32'(Fetch_Valid),  32'd0);
    mem.Imem_Ack = 1'b1;
    #1;
    chk("mrst_ack_busy", 32'(Fetch_Busy), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(mem.Imem_Req), 32'd0);
    tick();
    mem.Imem_Ack = 1'b0;
    #1;
    chk("restart_addr", mem.Imem_Addr,     32'h0);
    chk("restart_req",  32'(mem.Imem_Req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
